// File: rtl/morph_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : morph_frame_ctrl
//  Brief    : Frame sequencer for the 3x3 binary morphology datapath. Arms on
//             a start pulse, latches the operation mode, forwards the serial
//             pixel stream with position tracking and SOF/EOF markers, counts
//             datapath outputs to detect completion, and flags drop, overrun
//             and drain-timeout errors.
//  Revision : 1.0 - initial release
// ============================================================================
module morph_frame_ctrl #(
    parameter int COL_NUM = 1024,
    parameter int ROW_NUM = 720,
    parameter int OUT_NUM = 733796,
    parameter int TIMEOUT = 4096
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode_in,
    input  logic        src_data,
    input  logic        src_flag,
    output logic        dp_data,
    output logic        dp_flag,
    input  logic        dp_po_flag,
    output logic [1:0]  mode,
    output logic [10:0] col_cnt,
    output logic [9:0]  row_cnt,
    output logic        sof,
    output logic        eof,
    output logic        busy,
    output logic        done,
    output logic        err_drop,
    output logic        err_overrun,
    output logic        err_timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [10:0]       c_COL_LAST = 11'(COL_NUM - 1);
    localparam logic [9:0]        c_ROW_LAST = 10'(ROW_NUM - 1);
    localparam logic [19:0]       c_OUT_NUM  = 20'(OUT_NUM);
    localparam logic [IDLE_W-1:0] c_TIMEOUT  = IDLE_W'(TIMEOUT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_dp_data;
    logic              r_dp_flag;
    logic [1:0]        r_mode;
    logic [10:0]       r_col_cnt;
    logic [9:0]        r_row_cnt;
    logic              r_first;
    logic              r_sof;
    logic              r_eof;
    logic              r_busy;
    logic              r_done;
    logic              r_err_drop;
    logic              r_err_overrun;
    logic              r_err_timeout;
    logic [19:0]       r_out_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;

    logic              w_accept;
    logic              w_fwd;
    logic [10:0]       w_col_nxt;
    logic [9:0]        w_row_nxt;
    logic              w_last_px;
    logic              w_po_live;
    logic              w_out_full;
    logic              w_out_inc;
    logic              w_out_reach;
    logic [IDLE_W-1:0] w_idle_nxt;
    logic              w_idle_expire;
    logic              w_set_timeout;

    // Event decodes shared by the FSM and the datapath registers
    always_comb begin
        w_accept  = (r_state == c_ST_IDLE) && start;
        w_fwd     = (r_state == c_ST_RUN) && src_flag;

        // The first pixel after arming lands at (0,0); afterwards advance
        // along the row and wrap into the next row.
        w_col_nxt = 11'd0;
        w_row_nxt = 10'd0;
        if (!r_first) begin
            if (r_col_cnt == c_COL_LAST) begin
                w_col_nxt = 11'd0;
                w_row_nxt = r_row_cnt + 10'(1);
            end else begin
                w_col_nxt = r_col_cnt + 11'(1);
                w_row_nxt = r_row_cnt;
            end
        end
        w_last_px = w_fwd && (w_col_nxt == c_COL_LAST) && (w_row_nxt == c_ROW_LAST);

        w_po_live   = ((r_state == c_ST_RUN) || (r_state == c_ST_DRAIN)) && dp_po_flag;
        w_out_full  = (r_out_cnt == c_OUT_NUM);
        w_out_inc   = w_po_live && !w_out_full;
        w_out_reach = w_out_inc && ((r_out_cnt + 20'(1)) == c_OUT_NUM);

        // An output in the same cycle clears the idle count, so a final
        // output always wins over a coincident timeout.
        w_idle_nxt    = dp_po_flag ? '0 : (r_idle_cnt + IDLE_W'(1));
        w_idle_expire = (w_idle_nxt == c_TIMEOUT);
        w_set_timeout = (r_state == c_ST_DRAIN) && w_idle_expire
                        && !w_out_full && !w_out_reach;
    end

    // State register
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_last_px) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_out_full || w_out_reach || w_idle_expire) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Pixel forwarding, position tracking and frame markers
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_dp_data <= 1'b0;
            r_dp_flag <= 1'b0;
            r_mode    <= 2'b00;
            r_col_cnt <= 11'd0;
            r_row_cnt <= 10'd0;
            r_first   <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
        end else begin
            r_dp_flag <= w_fwd;
            r_sof     <= w_fwd && r_first;
            r_eof     <= w_last_px;
            if (w_fwd) begin
                r_dp_data <= src_data;
                r_col_cnt <= w_col_nxt;
                r_row_cnt <= w_row_nxt;
                r_first   <= 1'b0;
            end
            if (w_accept) begin
                r_mode    <= (mode_in == 2'b11) ? 2'b00 : mode_in;
                r_col_cnt <= 11'd0;
                r_row_cnt <= 10'd0;
                r_first   <= 1'b1;
            end
        end
    end

    // Output counting, drain idle timer, status decodes and sticky errors
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_out_cnt     <= 20'd0;
            r_idle_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_drop    <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_busy <= (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
            r_done <= (r_state == c_ST_DONE);
            if (w_accept) begin
                r_out_cnt     <= 20'd0;
                r_idle_cnt    <= '0;
                r_err_drop    <= 1'b0;
                r_err_overrun <= 1'b0;
                r_err_timeout <= 1'b0;
            end else begin
                if (w_out_inc) begin
                    r_out_cnt <= r_out_cnt + 20'(1);
                end
                if (w_po_live && w_out_full) begin
                    r_err_overrun <= 1'b1;
                end
                if (r_state == c_ST_DRAIN) begin
                    r_idle_cnt <= w_idle_nxt;
                end
                if (w_set_timeout) begin
                    r_err_timeout <= 1'b1;
                end
            end
            // A pixel arriving outside RUN is lost; record it even if a
            // start is accepted in the same cycle.
            if (src_flag && (r_state != c_ST_RUN)) begin
                r_err_drop <= 1'b1;
            end
        end
    end

    assign dp_data     = r_dp_data;
    assign dp_flag     = r_dp_flag;
    assign mode        = r_mode;
    assign col_cnt     = r_col_cnt;
    assign row_cnt     = r_row_cnt;
    assign sof         = r_sof;
    assign eof         = r_eof;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_drop    = r_err_drop;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_morph_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morph_frame_ctrl
//  Brief    : Self-checking bench for morph_frame_ctrl on a 4x3 frame with a
//             frame-level reference model (pixel index, output tally).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_morph_frame_ctrl;

    localparam int C_COL = 4;
    localparam int C_ROW = 3;
    localparam int C_OUT = 2;
    localparam int C_TO  = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode_in = 2'b00;
    logic        src_data = 1'b0;
    logic        src_flag = 1'b0;
    logic        dp_po_flag = 1'b0;
    logic        dp_data;
    logic        dp_flag;
    logic [1:0]  mode;
    logic [10:0] col_cnt;
    logic [9:0]  row_cnt;
    logic        sof, eof, busy, done, err_drop, err_overrun, err_timeout;

    morph_frame_ctrl #(
        .COL_NUM(C_COL),
        .ROW_NUM(C_ROW),
        .OUT_NUM(C_OUT),
        .TIMEOUT(C_TO)
    ) u_dut (
        .sclk        (sclk),
        .rst         (rst),
        .start       (start),
        .mode_in     (mode_in),
        .src_data    (src_data),
        .src_flag    (src_flag),
        .dp_data     (dp_data),
        .dp_flag     (dp_flag),
        .dp_po_flag  (dp_po_flag),
        .mode        (mode),
        .col_cnt     (col_cnt),
        .row_cnt     (row_cnt),
        .sof         (sof),
        .eof         (eof),
        .busy        (busy),
        .done        (done),
        .err_drop    (err_drop),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;

    // Reference model: frame phase, pixel index, output tally, idle run
    int       m_ph   = PH_IDLE;
    int       m_npix = 0;
    int       m_outs = 0;
    int       m_idle = 0;
    bit [1:0] e_mode = 2'b00;
    int       e_col  = 0;
    int       e_row  = 0;
    bit       e_dpflag, e_dpdata, e_sof, e_eof, e_busy, e_done;
    bit       e_drop, e_ovr, e_to;

    int cyc = 0;
    int done_seen = 0;
    int eof_cyc = -1;
    int done_cyc = -1;
    logic [10:0] eof_col;
    logic [9:0]  eof_row;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit [1:0] mi,
                              input bit sf, input bit sd, input bit po);
        int  nph;
        bit  counting;
        if (r) begin
            m_ph = PH_IDLE; m_npix = 0; m_outs = 0; m_idle = 0;
            e_mode = 2'b00; e_col = 0; e_row = 0;
            e_dpflag = 0; e_dpdata = 0; e_sof = 0; e_eof = 0; e_busy = 0; e_done = 0;
            e_drop = 0; e_ovr = 0; e_to = 0;
            return;
        end
        nph      = m_ph;
        e_busy   = (m_ph == PH_RUN) || (m_ph == PH_DRAIN);
        e_done   = (m_ph == PH_DONE);
        counting = e_busy;
        e_dpflag = 0; e_sof = 0; e_eof = 0;
        if (m_ph == PH_IDLE && st) begin
            e_mode = (mi == 2'b11) ? 2'b00 : mi;
            e_col = 0; e_row = 0;
            m_npix = 0; m_outs = 0; m_idle = 0;
            e_drop = 0; e_ovr = 0; e_to = 0;
            nph = PH_RUN;
        end
        if (sf && m_ph != PH_RUN) e_drop = 1;
        if (m_ph == PH_RUN && sf) begin
            e_dpflag = 1;
            e_dpdata = sd;
            e_col    = m_npix % C_COL;
            e_row    = m_npix / C_COL;
            e_sof    = (m_npix == 0);
            e_eof    = (m_npix == C_COL * C_ROW - 1);
            m_npix++;
            if (e_eof) nph = PH_DRAIN;
        end
        if (counting && po) begin
            if (m_outs == C_OUT) e_ovr = 1;
            else m_outs++;
        end
        if (m_ph == PH_DRAIN) begin
            m_idle = po ? 0 : m_idle + 1;
            if (m_outs == C_OUT) nph = PH_DONE;
            else if (m_idle == C_TO) begin
                e_to = 1;
                nph  = PH_DONE;
            end
        end
        if (m_ph == PH_DONE) nph = PH_IDLE;
        m_ph = nph;
    endtask

    task automatic step(input bit r, input bit st, input bit [1:0] mi,
                        input bit sf, input bit sd, input bit po);
        rst = r; start = st; mode_in = mi; src_flag = sf; src_data = sd; dp_po_flag = po;
        @(posedge sclk);
        model_step(r, st, mi, sf, sd, po);
        #1;
        cyc++;
        check("outputs",
              {20'd0, dp_flag, dp_data, mode, sof, eof, busy, done, err_drop, err_overrun, err_timeout},
              {20'd0, e_dpflag, e_dpdata, e_mode, e_sof, e_eof, e_busy, e_done, e_drop, e_ovr, e_to});
        check("position", {11'd0, row_cnt, col_cnt}, {11'd0, e_row[9:0], e_col[10:0]});
        if (eof) begin
            eof_cyc = cyc; eof_col = col_cnt; eof_row = row_cnt;
        end
        if (done) begin
            done_seen++; done_cyc = cyc;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0, 0);
    endtask

    // Idles until a done pulse or the budget runs out; an expired budget fails
    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < budget && done_seen == d0; i++) step(0, 0, 2'b00, 0, 0, 0);
        check(tag, done_seen - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;

        // Reset state
        step(1, 0, 2'b00, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0);
        check("reset_zero",
              {9'd0, dp_flag, dp_data, mode, sof, eof, busy, done, err_drop, err_overrun, err_timeout, row_cnt, col_cnt},
              32'd0);

        // Dilate frame: 12 alternating pixels, then two outputs
        d0 = done_seen;
        step(0, 1, 2'b01, 0, 0, 0);
        check("t1_mode", {30'd0, mode}, 32'd1);
        for (int i = 0; i < 12; i++) step(0, 0, 2'b00, 1, (i % 2 == 0), 0);
        check("t1_eof_pos", {11'd0, eof_row, eof_col}, {11'd0, 10'd2, 11'd3});
        step(0, 0, 2'b00, 0, 0, 1);
        step(0, 0, 2'b00, 0, 0, 1);
        idle_cycles(4);
        check("t1_done_once", done_seen - d0, 1);
        check("t1_no_err", {29'd0, err_drop, err_overrun, err_timeout}, 32'd0);

        // Pixels without start are dropped; the next start clears the flag
        for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 1, 1, 0);
        check("t2_drop_set", {30'd0, err_drop, dp_flag}, {30'd0, 1'b1, 1'b0});
        step(0, 1, 2'b10, 0, 0, 0);
        check("t2_drop_clr", {31'd0, err_drop}, 32'd0);
        step(1, 0, 2'b00, 0, 0, 0);

        // Full frame with no outputs: drain timeout
        step(0, 1, 2'b10, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 2'b00, 1, 1'($urandom_range(0, 1)), 0);
        wait_done("t3_done_seen", 20);
        check("t3_done_lat", done_cyc - eof_cyc, 9);
        check("t3_timeout", {31'd0, err_timeout}, 32'd1);

        // Three outputs during the frame with OUT_NUM=2: overrun
        step(0, 1, 2'b01, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 2'b00, 1, 1'($urandom_range(0, 1)), (i == 2 || i == 5 || i == 8));
        wait_done("t4_done_seen", 10);
        check("t4_overrun", {30'd0, err_overrun, err_timeout}, {30'd0, 1'b1, 1'b0});
        check("t4_done_lat", done_cyc - eof_cyc, 2);

        // Reset mid-RUN at pixel 5, then a clean restart at (0,0)
        d0 = done_seen;
        step(0, 1, 2'b01, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 2'b00, 1, 1, 1);
        step(1, 0, 2'b00, 0, 0, 0);
        check("t5_rst_zero",
              {9'd0, dp_flag, dp_data, mode, sof, eof, busy, done, err_drop, err_overrun, err_timeout, row_cnt, col_cnt},
              32'd0);
        idle_cycles(12);
        check("t5_no_done", done_seen - d0, 0);
        step(0, 1, 2'b10, 0, 0, 0);
        step(0, 0, 2'b00, 1, 1, 0);
        check("t5_restart", {10'd0, sof, dp_flag, row_cnt, col_cnt}, {10'd0, 1'b1, 1'b1, 10'd0, 11'd0});
        step(1, 0, 2'b00, 0, 0, 0);

        // Reserved mode maps to bypass; start while busy is ignored
        step(0, 1, 2'b11, 0, 0, 0);
        check("t6_mode_rsv", {30'd0, mode}, 32'd0);
        step(0, 0, 2'b00, 1, 0, 0);
        step(0, 0, 2'b00, 1, 1, 0);
        step(0, 1, 2'b01, 1, 0, 0);
        check("t6_start_busy", {9'd0, mode, row_cnt, col_cnt}, {9'd0, 2'b00, 10'd0, 11'd2});
        step(1, 0, 2'b00, 0, 0, 0);

        // Random frames: gapped pixels, random outputs, stray starts/pixels
        for (int f = 0; f < 8; f++) begin
            step(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
            n = 0;
            while (m_ph != PH_IDLE && n < 300) begin
                step(0, ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0));
                n++;
            end
            check("rnd_frame_end", {31'd0, n < 300}, 32'd1);
            idle_cycles(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morph_frame_ctrl.md
Name: morph_frame_ctrl

Overview:
Frame-level sequencer in front of the 3x3 binary morphology datapath (window buffer plus dilate/erode core). It arms on a host start pulse, latches the operation mode, and gates the serial pixel stream into the datapath. It tracks column/row position, marks start and end of frame, counts datapath output pixels to detect frame completion, and reports drop, overrun and timeout errors.

Parameters:
COL_NUM, 1024, pixels per row
ROW_NUM, 720, rows per frame
OUT_NUM, 733796, expected datapath output pixels per frame ((ROW_NUM-2)*(COL_NUM-2))
TIMEOUT, 4096, maximum idle cycles allowed between outputs in DRAIN

Ports:
sclk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle arm request
mode_in  in  2  00 bypass, 01 dilate, 10 erode, 11 reserved (treated as bypass)
src_data  in  1  incoming binary pixel
src_flag  in  1  src_data valid
dp_data  out  1  pixel to datapath
dp_flag  out  1  dp_data valid
dp_po_flag  in  1  datapath output-pixel valid
mode  out  2  mode latched for the current frame
col_cnt  out  11  column of the last forwarded pixel
row_cnt  out  10  row of the last forwarded pixel
sof  out  1  pulse aligned with the first dp_flag of the frame
eof  out  1  pulse aligned with the last dp_flag of the frame
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle completion pulse
err_drop  out  1  sticky: src_flag received while not in RUN
err_overrun  out  1  sticky: dp_po_flag received after OUT_NUM outputs
err_timeout  out  1  sticky: DRAIN timeout expired

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset applies in any state; an in-progress frame is abandoned and no done pulse is produced.
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - start=1: latch mode (11 becomes 00), clear col/row/output/timeout counters and all three error flags, then go to RUN on the next cycle.
  - src_flag=1: dropped, err_drop is set, dp_flag stays 0.
- RUN:
  - Each src_flag=1 produces dp_flag=1 and dp_data=src_data on the next cycle (fixed 1-cycle latency). When src_flag=0, dp_flag=0 and dp_data holds its value.
  - Position counters, updated together with dp_flag:
    - The first pixel of a frame is (row 0, col 0).
    - col_cnt wraps at COL_NUM-1 back to 0 and row_cnt increments on the wrap.
  - sof is high with the dp_flag of (0,0). eof is high with the dp_flag of (ROW_NUM-1, COL_NUM-1). On that same cycle the state becomes DRAIN.
  - start while busy is ignored, with no effect on mode or counters.
- Output counting:
  - In RUN and DRAIN, each dp_po_flag increments out_cnt (20 bits, saturating at OUT_NUM).
  - A dp_po_flag that arrives when out_cnt==OUT_NUM is ignored and sets err_overrun.
- DRAIN:
  - src_flag is dropped and sets err_drop.
  - The idle counter clears on every dp_po_flag and otherwise increments.
  - Go to DONE when out_cnt reaches OUT_NUM. If the idle counter reaches TIMEOUT first, set err_timeout and go to DONE.
  - If the final output and the timeout expiry occur in the same cycle, the output takes priority: the output is counted and err_timeout is not set.
  - If out_cnt already equals OUT_NUM on entry to DRAIN, go to DONE on the following cycle.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0. A start in DONE is ignored.
- busy is a registered decode of the state. Error flags hold until the next accepted start or reset.

Test Plan:
- COL_NUM=4, ROW_NUM=3, OUT_NUM=2, TIMEOUT=8; start, mode_in=01, then 12 consecutive src_flag pulses with alternating data 1/0 -> dp_flag/dp_data delayed 1 cycle; sof on the first; eof on the 12th with col_cnt=3, row_cnt=2; mode=01; 2 dp_po_flag pulses -> done pulses once, busy drops, no errors.
- src_flag pulses with no start -> dp_flag stays 0, err_drop=1; a subsequent start clears err_drop to 0.
- Full frame followed by no dp_po_flag -> err_timeout=1 and done exactly 9 cycles after DRAIN entry (TIMEOUT=8 plus 1 cycle in DONE).
- Three dp_po_flag pulses during the frame with OUT_NUM=2 -> err_overrun=1; done follows the cycle after eof.
- Assert rst mid-RUN at pixel 5 -> all outputs 0 next cycle, no done; a new start begins at (0,0) with sof.
- start with mode_in=11 -> mode=00; a second start during RUN is ignored and mode stays 00.
